// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter feeding a registered valid/ready select stage
//
// Four requesters (a, b, c, d) share one 4-way select datapath. One winner is picked
// per load cycle, scanning from a rotating pointer. The winner's word and its index
// are captured into a single output register.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   req[3:0]    request per source (bit0=a .. bit3=d)
//   a,b,c,d     source data words, DW bits each
//   lock[3:0]   burst-lock per source (only honoured with MUX_ARB_LOCK_EN)
//   gnt[3:0]    one-hot grant, combinational, high only in the load cycle
//   y[1:0]      registered select code of the word in dout
//   dout        registered selected data
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout this cycle
//
// Build option: define MUX_ARB_LOCK_EN to let a locked last-granted source keep
// the grant without advancing the rotation pointer.

module mux_rr_arbiter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    input  logic [3:0]    lock,
    output logic [3:0]    gnt,
    output logic [1:0]    y,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [1:0]    last;
    logic          load;
    logic          lock_hit;
    logic [1:0]    rr_win;
    logic [1:0]    win;
    logic [DW-1:0] sel_data;

    assign dout_valid = (state == FULL);

    // The output stage is free when empty or when its word leaves this same edge.
    assign load = (|req) & (~dout_valid | dout_ready) & ~rst;

    // Scan from ptr+3 down to ptr so the lowest rotation offset is written last and wins.
    always_comb begin
        logic [1:0] idx;
        rr_win = ptr;
        idx    = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                rr_win = idx;
            end
        end
    end

`ifdef MUX_ARB_LOCK_EN
    assign lock_hit = req[last] & lock[last];
`else
    // Lock is ignored in this build; the term is constant-zero.
    assign lock_hit = lock[last] & 1'b0;
`endif

    assign win = lock_hit ? last : rr_win;

    always_comb begin
        sel_data = a;
        case (win)
            2'd0:    sel_data = a;
            2'd1:    sel_data = b;
            2'd2:    sel_data = c;
            default: sel_data = d;
        endcase
    end

    assign gnt = load ? (4'b0001 << win) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            dout  <= '0;
            y     <= 2'b00;
            ptr   <= 2'b00;
            last  <= 2'b00;
        end else if (load) begin
            // Covers both EMPTY->FULL and the zero-bubble consume-and-reload in FULL.
            state <= FULL;
            dout  <= sel_data;
            y     <= win;
            last  <= win;
            if (!lock_hit) begin
                ptr <= win + 2'd1;
            end
        end else if (state == FULL && dout_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed table-driven bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] a, b, c, d;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] y;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    int n_vec;
    int n_bad;

    mux_rr_arbiter #(.DW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .lock       (lock),
        .gnt        (gnt),
        .y          (y),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic [15:0] data;     // {d, c, b, a}
        logic [3:0]  exp_gnt;  // before the edge
        logic        exp_v;    // after the edge
        logic [3:0]  exp_dout;
        logic [1:0]  exp_y;
    } vec_t;

    localparam int NV = 20;
    vec_t vec [NV];

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [3:0] lk_gnt [5];
        logic [1:0] lk_y   [5];
        n_vec = 0;
        n_bad = 0;

        // reset hold with all requests
        vec[0]  = '{1'b1, 4'hF, 1'b1, 16'h4321, 4'b0000, 1'b0, 4'h0, 2'd0};
        vec[1]  = '{1'b1, 4'hF, 1'b1, 16'h4321, 4'b0000, 1'b0, 4'h0, 2'd0};
        // full rotation a,b,c,d,a
        vec[2]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0};
        vec[3]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b0010, 1'b1, 4'h2, 2'd1};
        vec[4]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b0100, 1'b1, 4'h3, 2'd2};
        vec[5]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b1000, 1'b1, 4'h4, 2'd3};
        vec[6]  = '{1'b0, 4'hF, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0};
        // pointer wrap: grant d, then a wins over c
        vec[7]  = '{1'b0, 4'h8, 1'b1, 16'h4321, 4'b1000, 1'b1, 4'h4, 2'd3};
        vec[8]  = '{1'b0, 4'h5, 1'b1, 16'h4321, 4'b0001, 1'b1, 4'h1, 2'd0};
        // idle: word drains, dout holds
        vec[9]  = '{1'b0, 4'h0, 1'b1, 16'h4321, 4'b0000, 1'b0, 4'h1, 2'd0};
        vec[10] = '{1'b0, 4'h0, 1'b0, 16'h4321, 4'b0000, 1'b0, 4'h1, 2'd0};
        // backpressure: load c into empty stage, then b stalls 3 cycles
        vec[11] = '{1'b0, 4'h4, 1'b0, 16'h4321, 4'b0100, 1'b1, 4'h3, 2'd2};
        vec[12] = '{1'b0, 4'h2, 1'b0, 16'h4321, 4'b0000, 1'b1, 4'h3, 2'd2};
        vec[13] = '{1'b0, 4'h2, 1'b0, 16'h4321, 4'b0000, 1'b1, 4'h3, 2'd2};
        vec[14] = '{1'b0, 4'h2, 1'b0, 16'h4321, 4'b0000, 1'b1, 4'h3, 2'd2};
        vec[15] = '{1'b0, 4'h2, 1'b1, 16'h4321, 4'b0010, 1'b1, 4'h2, 2'd1};
        vec[16] = '{1'b0, 4'h0, 1'b0, 16'h4321, 4'b0000, 1'b1, 4'h2, 2'd1};
        // reset mid-transfer, then ptr back at a (other data pattern)
        vec[17] = '{1'b1, 4'hF, 1'b0, 16'h4321, 4'b0000, 1'b0, 4'h0, 2'd0};
        vec[18] = '{1'b0, 4'hF, 1'b1, 16'h9ABC, 4'b0001, 1'b1, 4'hC, 2'd0};
        vec[19] = '{1'b0, 4'h0, 1'b1, 16'h9ABC, 4'b0000, 1'b0, 4'hC, 2'd0};

        rst = 1'b1; req = 4'h0; lock = 4'h0; dout_ready = 1'b0;
        {d, c, b, a} = 16'h4321;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vec[i].rst;
            req = vec[i].req;
            dout_ready = vec[i].rdy;
            {d, c, b, a} = vec[i].data;
            #1;
            check("gnt", i, 16'(gnt), 16'(vec[i].exp_gnt));
            @(posedge clk);
            #1;
            check("dout_valid", i, 16'(dout_valid), 16'(vec[i].exp_v));
            check("dout", i, 16'(dout), 16'(vec[i].exp_dout));
            check("y", i, 16'(y), 16'(vec[i].exp_y));
        end

        // Lock sequence: ptr=1, last=a at this point; four loads with lock on b, then lock drops.
`ifdef MUX_ARB_LOCK_EN
        lk_gnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        lk_y   = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
`else
        lk_gnt = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
        lk_y   = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
        {d, c, b, a} = 16'h4321;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req = 4'b0011;
            lock = (i < 4) ? 4'b0010 : 4'b0000;
            dout_ready = 1'b1;
            #1;
            check("lock_gnt", i, 16'(gnt), 16'(lk_gnt[i]));
            @(posedge clk);
            #1;
            check("lock_y", i, 16'(y), 16'(lk_y[i]));
            check("lock_dout", i, 16'(dout), 16'(lk_y[i]) + 16'd1);
        end

        @(negedge clk);
        req = 4'h0;
        lock = 4'h0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
